// File: rtl/score_credit_tx_if.sv
// Handshake interfaces for score_credit_tx.
//   score_stream_if : valid/ready score beats entering the block.
//   score_credit_if : credit-based outgoing link (no ready; credits flow back).
interface score_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

interface score_credit_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              crd_return;

    modport master (output data, output valid, output last, input  crd_return);
    modport slave  (input  data, input  valid, input  last, output crd_return);
endinterface

// File: rtl/score_credit_tx.sv
// score_credit_tx: buffers 8-bit attention scores in a small circular FIFO and
// forwards them over a credit-based link, one beat per available credit, framing
// the outgoing stream into SEQ_LEN-beat sequences with a last flag.
// Optional credit-overflow checker: define CREDIT_OVF_CHK_EN to enable err_ovf.
module score_credit_tx #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_CREDITS = 4,
    parameter int SEQ_LEN     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    score_stream_if.slave               s_if,
    score_credit_if.master              m_if,
    output logic [3:0]                  credits,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    typedef logic [AW:0]   ptr_t;
    typedef logic [BW-1:0] beat_t;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CRD   = 4'(MAX_CREDITS);
    localparam beat_t      LAST_BEAT = beat_t'(SEQ_LEN - 1);

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    ptr_t              wr_ptr_r;
    ptr_t              rd_ptr_r;
    logic [3:0]        credits_r;
    ptr_t              level_r;
    beat_t             beat_r;
    state_t            state_r;
    logic [DATA_W-1:0] m_data_r;
    logic              m_valid_r;
    logic              m_last_r;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    ptr_t              wr_nxt_s;
    ptr_t              rd_nxt_s;
    ptr_t              level_nxt_s;
    logic [3:0]        crd_nxt_s;
    state_t            state_nxt_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                     (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign push_s  = s_if.valid && !full_s;
    // state_r always mirrors the current pointers and credit count, so SEND
    // means exactly "non-empty and a credit is available".
    assign pop_s   = (state_r == ST_SEND);

    assign s_if.ready  = !full_s;
    assign m_if.data   = m_data_r;
    assign m_if.valid  = m_valid_r;
    assign m_if.last   = m_last_r;
    assign credits     = credits_r;
    assign fifo_level  = level_r;

    // Next pointers, saturating credit count and controller state.
    always_comb begin
        wr_nxt_s    = wr_ptr_r;
        rd_nxt_s    = rd_ptr_r;
        crd_nxt_s   = credits_r;
        state_nxt_s = ST_IDLE;

        if (push_s) begin
            wr_nxt_s = wr_ptr_r + ptr_t'(1);
        end else begin
            wr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + ptr_t'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end

        case ({pop_s, m_if.crd_return})
            2'b10: crd_nxt_s = credits_r - 4'd1;
            2'b01: begin
                // A return with a full credit pool is ignored.
                if (credits_r == MAX_CRD) begin
                    crd_nxt_s = credits_r;
                end else begin
                    crd_nxt_s = credits_r + 4'd1;
                end
            end
            default: crd_nxt_s = credits_r;
        endcase

        level_nxt_s = wr_nxt_s - rd_nxt_s;

        if (level_nxt_s == ptr_t'(0)) begin
            state_nxt_s = ST_IDLE;
        end else if (crd_nxt_s != 4'd0) begin
            state_nxt_s = ST_SEND;
        end else begin
            state_nxt_s = ST_STALL;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= s_if.data;
        end
    end

    // Controller: pointers, credits, state, beat counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= ptr_t'(0);
            rd_ptr_r  <= ptr_t'(0);
            level_r   <= ptr_t'(0);
            credits_r <= MAX_CRD;
            beat_r    <= beat_t'(0);
            state_r   <= ST_IDLE;
            m_data_r  <= {DATA_W{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_nxt_s;
            rd_ptr_r  <= rd_nxt_s;
            level_r   <= level_nxt_s;
            credits_r <= crd_nxt_s;
            state_r   <= state_nxt_s;
            if (pop_s) begin
                m_data_r  <= mem_r[rd_ptr_r[AW-1:0]];
                m_valid_r <= 1'b1;
                m_last_r  <= (beat_r == LAST_BEAT);
                if (beat_r == LAST_BEAT) begin
                    beat_r <= beat_t'(0);
                end else begin
                    beat_r <= beat_r + beat_t'(1);
                end
            end else begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end
        end
    end

`ifdef CREDIT_OVF_CHK_EN
    logic err_ovf_r;
    logic ovf_s;

    assign ovf_s   = m_if.crd_return && !pop_s && (credits_r == MAX_CRD);
    assign err_ovf = err_ovf_r;

    // Sticky flag for a credit return that would exceed the pool size.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_r <= 1'b0;
        end else if (ovf_s) begin
            err_ovf_r <= 1'b1;
        end
    end
`else
    assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_score_credit_tx.sv
// Directed self-checking bench for score_credit_tx.
module tb_score_credit_tx;

    localparam int SEQ_LEN = 8;
`ifdef CREDIT_OVF_CHK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] credits;
    logic [2:0] fifo_level;
    logic       err_ovf;

    score_stream_if #(.DATA_W(8)) s_bus ();
    score_credit_if #(.DATA_W(8)) m_bus ();

    score_credit_tx #(
        .DATA_W(8), .FIFO_DEPTH(4), .MAX_CREDITS(4), .SEQ_LEN(SEQ_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_if(s_bus.slave), .m_if(m_bus.master),
        .credits(credits), .fifo_level(fifo_level), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int sent = 0;
    int nlast = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and score any beat emitted on it.
    task automatic step();
        @(posedge clk);
        #1;
        if (m_bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexp_send", 32'(m_bus.valid), 32'd0);
            end else begin
                check("send_data", 32'(m_bus.data), 32'(exp_q.pop_front()));
                check("send_last", 32'(m_bus.last), 32'((sent % SEQ_LEN) == SEQ_LEN - 1));
                if (m_bus.last) nlast++;
                sent++;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        s_bus.valid      = v;
        s_bus.data       = d;
        m_bus.crd_return = r;
        if (v) begin
            check("push_rdy", 32'(s_bus.ready), 32'd1);
            exp_q.push_back(d);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        sent  = 0;
        nlast = 0;
    endtask

    // n beats, one per cycle, with a credit returned on every sending edge.
    task automatic stream(input int n, input logic [7:0] base);
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(1'b1, base + 8'(i), i >= 1);
            else       drive(1'b0, 8'h00, 1'b1);
            step();
            if (i >= 1) begin
                check("strm_valid", 32'(m_bus.valid), 32'd1);
                check("strm_crd", 32'(credits), 32'd4);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("strm_end_valid", 32'(m_bus.valid), 32'd0);
        check("strm_end_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        s_bus.valid = 1'b0;
        s_bus.data = 8'h00;
        m_bus.crd_return = 1'b0;

        // Reset values
        reset_dut();
        check("rst_mdata", 32'(m_bus.data), 32'd0);
        check("rst_mvalid", 32'(m_bus.valid), 32'd0);
        check("rst_mlast", 32'(m_bus.last), 32'd0);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_err", 32'(err_ovf), 32'd0);
        check("rst_ready", 32'(s_bus.ready), 32'd1);

        // Single beat latency
        drive(1'b1, 8'h11, 1'b0);
        step();
        check("lat_level1", 32'(fifo_level), 32'd1);
        check("lat_novalid", 32'(m_bus.valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("lat_valid", 32'(m_bus.valid), 32'd1);
        check("lat_data", 32'(m_bus.data), 32'h11);
        check("lat_credits", 32'(credits), 32'd3);
        check("lat_level0", 32'(fifo_level), 32'd0);
        step();
        check("lat_pulse", 32'(m_bus.valid), 32'd0);

        // Burst of 6 with only 4 credits
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check("burst_sent", 32'(sent), 32'd4);
        check("burst_crd0", 32'(credits), 32'd0);
        check("burst_level", 32'(fifo_level), 32'd2);
        check("burst_ready", 32'(s_bus.ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check("burst_sent6", 32'(sent), 32'd6);
        check("burst_drained", 32'(exp_q.size()), 32'd0);
        check("burst_level0", 32'(fifo_level), 32'd0);

        // Continuous stream with matched returns, two sequences
        reset_dut();
        stream(16, 8'h40);
        check("strm_nlast", 32'(nlast), 32'd2);
        check("strm_sent", 32'(sent), 32'd16);
        check("strm_noerr", 32'(err_ovf), 32'd0);

        // Credit return with a full pool
        reset_dut();
        drive(1'b0, 8'h00, 1'b1);
        step();
        check("sat_credits", 32'(credits), 32'd4);
        check("ovf_set", 32'(err_ovf), 32'(OVF_EN));
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check("ovf_sticky", 32'(err_ovf), 32'(OVF_EN));
        check("sat_after_send", 32'(credits), 32'd3);

        // Fill the FIFO with no credits left
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h21 + 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check("fill_crd0", 32'(credits), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h31 + 8'(i), 1'b0);
            step();
        end
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(s_bus.ready), 32'd0);
        s_bus.valid = 1'b1;
        s_bus.data  = 8'h99;
        step();
        check("full_reject", 32'(fifo_level), 32'd4);
        drive(1'b0, 8'h00, 1'b1);
        step();
        check("ret_level", 32'(fifo_level), 32'd4);
        check("ret_ready0", 32'(s_bus.ready), 32'd0);
        check("ret_crd1", 32'(credits), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("ret_pop", 32'(m_bus.valid), 32'd1);
        check("ret_level3", 32'(fifo_level), 32'd3);
        check("ret_ready1", 32'(s_bus.ready), 32'd1);

        // Reset mid-operation: 3 queued, one credit, send pending
        drive(1'b0, 8'h00, 1'b1);
        step();
        check("mid_crd1", 32'(credits), 32'd1);
        check("mid_level3", 32'(fifo_level), 32'd3);
        reset_dut();
        check("mid_level0", 32'(fifo_level), 32'd0);
        check("mid_credits", 32'(credits), 32'd4);
        check("mid_nosend", 32'(m_bus.valid), 32'd0);
        stream(8, 8'h80);
        check("mid_nlast", 32'(nlast), 32'd1);
        check("mid_sent", 32'(sent), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_credit_tx.md
Name: score_credit_tx

Overview:
- Downstream stage of the attention MAC core.
- Accepts 8-bit score beats over a valid/ready slave port and buffers them in a small circular FIFO.
- Forwards beats over a credit-based master link: one beat per available credit, credits returned by the consumer as single-cycle pulses.
- Frames the outgoing stream into sequences of SEQ_LEN beats with a last flag.

Parameters:
- DATA_W, 8: score beat width.
- FIFO_DEPTH, 4: FIFO entries; power of two, >= 2.
- MAX_CREDITS, 4: credits held after reset, equal to the consumer buffer size; 1..15.
- SEQ_LEN, 8: beats per sequence; >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_data  in  DATA_W  score from MAC stage
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept
- m_data  out  DATA_W  outgoing score, registered
- m_valid  out  1  one-cycle send pulse; no ready (credit link)
- m_last  out  1  qualifies m_valid; final beat of a sequence
- crd_return  in  1  one-cycle pulse, returns one credit
- credits  out  4  current credit count
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- err_ovf  out  1  credit overflow, sticky (feature only, else tied 0)

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk; all state on posedge clk.
- Reset values: m_data=0, m_valid=0, m_last=0, credits=MAX_CREDITS, fifo_level=0, err_ovf=0, beat counter=0. s_ready=1 in the first cycle after reset.
- Reset mid-operation: FIFO contents discarded, pointers cleared, credits restored, sequence restarts at beat 0. A pending m_valid is dropped.
- FIFO: read and write pointers carry an extra wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
  - Indices wrap modulo FIFO_DEPTH.
- Push: s_valid & s_ready; s_ready = !full (combinational, no dependence on s_valid).
- Pop (send): !empty & (credits != 0). The decision is combinational in the current cycle. A credit returned in the same cycle cannot enable a send from credits==0.
- Output registers: on a pop edge, m_data <= head entry, m_valid <= 1, m_last <= (beat == SEQ_LEN-1). Otherwise m_valid <= 0 and m_last <= 0; m_data holds its last value.
- Latency: a beat pushed at edge N into an empty FIFO with credits available produces m_valid high in cycle N+1..N+2, i.e. registered after edge N+1. No combinational bypass.
- Throughput: one beat per cycle while credits > 0 and the FIFO is non-empty.
- Simultaneous push and pop: allowed whenever not full and not empty; fifo_level is unchanged. No push while full, even if a pop occurs that cycle.
- Credit update: credits_next = credits - pop + crd_return. A simultaneous pop and return leaves credits unchanged.
- Credit saturation: if crd_return arrives with credits == MAX_CREDITS and no pop, the count stays at MAX_CREDITS and the return is ignored.
- Beat counter: 0..SEQ_LEN-1, increments on each pop, wraps to 0 after SEQ_LEN-1. With SEQ_LEN=1, m_last is 1 on every beat.
- Controller states:
  - IDLE: FIFO empty.
  - SEND: non-empty, credits > 0.
  - STALL: non-empty, credits == 0.
  - Transitions follow directly from fifo_level and credits each cycle. State is observable only through outputs.

Optional Feature:
- Macro CREDIT_OVF_CHK_EN.
- Defined: a crd_return that would push credits above MAX_CREDITS (return with credits==MAX_CREDITS and no pop) sets err_ovf on the next edge. err_ovf stays 1 until reset. Credits still saturate.
- Undefined: no checker logic; err_ovf tied to 0; saturation behaviour unchanged.

Test Plan:
- Reset, then push 0x11 at one edge with 4 credits -> m_valid=1, m_data=0x11 two edges later, credits=3, fifo_level back to 0.
- Burst 6 beats 0x01..0x06, no returns, MAX_CREDITS=4 -> exactly 4 sends (0x01..0x04), credits=0, fifo_level=2, s_ready=1. Pulse crd_return twice -> 0x05 and 0x06 sent in order.
- Hold credits at 0 and push until full -> fifo_level=4, s_ready=0, an extra s_valid beat is not accepted. One return -> one pop; s_ready=1 the next cycle.
- Stream 16 beats with a return every cycle -> continuous m_valid; m_last high on beats 8 and 16 only; credits remain 4 when returns coincide with pops.
- crd_return with credits=4 and no pop -> credits stays 4. err_ovf=1 with CREDIT_OVF_CHK_EN and stays 1; 0 without it.
- Assert rst_n=0 for one cycle with 3 beats queued and credits=1 -> fifo_level=0, credits=4, m_valid=0, next sequence starts at beat 0.
